// File: rtl/fft_r22sdf_bitrev.sv
// Natural-order reorder buffer for the radix-2^2 SDF FFT output.
// Ping-pong banks are filled by bin index and streamed out as bins 0..N-1.
module fft_r22sdf_bitrev #(
    parameter int N          = 1024,
    parameter int N_LOG2     = 10,
    parameter int DATA_WIDTH = 25
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [N_LOG2-1:0]     bin_i,
    input  logic [DATA_WIDTH-1:0] re_i,
    input  logic [DATA_WIDTH-1:0] im_i,
    output logic                  valid_o,
    output logic [N_LOG2-1:0]     bin_o,
    output logic [DATA_WIDTH-1:0] re_o,
    output logic [DATA_WIDTH-1:0] im_o,
    output logic                  first_o,
    output logic                  last_o,
    output logic                  err_o
);

    localparam int                WORD_W   = 2 * DATA_WIDTH;
    localparam logic [N_LOG2-1:0] LAST_BIN = N_LOG2'(N - 1);

    // Both banks share one array; the top address bit selects the bank.
    logic [WORD_W-1:0] r_mem [2*N];

    logic              r_wrBank;
    logic [N_LOG2-1:0] r_wrCnt;
    logic              r_rdBank;
    logic              r_rdActive;
    logic [N_LOG2-1:0] r_rdCnt;
    logic              r_err;
    logic [WORD_W-1:0] r_rdData;
    logic              r_valid;
    logic [N_LOG2-1:0] r_bin;
    logic              r_first;
    logic              r_last;

    logic              w_frameDone;
    logic              w_misaligned;
    logic              w_overrun;

    assign w_frameDone  = valid_i && (r_wrCnt == LAST_BIN);
    assign w_misaligned = valid_i && (r_wrCnt == '0) && (bin_i != '0);
    // Finishing a frame while the final address is being issued is the
    // normal back-to-back case, not an overrun.
    assign w_overrun    = w_frameDone && r_rdActive && (r_rdCnt != LAST_BIN);

    always_ff @(posedge clk_i) begin
        if (valid_i && !rst_i) begin
            r_mem[{r_wrBank, bin_i}] <= {re_i, im_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wrBank <= 1'b0;
            r_wrCnt  <= '0;
        end else if (valid_i) begin
            r_wrCnt <= r_wrCnt + 1'b1;
            if (w_frameDone) begin
                r_wrBank <= ~r_wrBank;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdActive <= 1'b0;
            r_rdCnt    <= '0;
            r_rdBank   <= 1'b0;
        end else if (w_frameDone) begin
            r_rdActive <= 1'b1;
            r_rdCnt    <= '0;
            r_rdBank   <= r_wrBank;
        end else if (r_rdActive) begin
            r_rdCnt <= r_rdCnt + 1'b1;
            if (r_rdCnt == LAST_BIN) begin
                r_rdActive <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_misaligned || w_overrun) begin
            r_err <= 1'b1;
        end
    end

    // Registered RAM read; the flag registers below carry the matching
    // address-phase information so both arrive on the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdData <= '0;
        end else if (r_rdActive) begin
            r_rdData <= r_mem[{r_rdBank, r_rdCnt}];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_bin   <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= r_rdActive;
            r_bin   <= r_rdCnt;
            r_first <= r_rdActive && (r_rdCnt == '0);
            r_last  <= r_rdActive && (r_rdCnt == LAST_BIN);
        end
    end

    assign valid_o = r_valid;
    assign bin_o   = r_bin;
    assign first_o = r_first;
    assign last_o  = r_last;
    assign err_o   = r_err;
    assign re_o    = r_rdData[WORD_W-1 -: DATA_WIDTH];
    assign im_o    = r_rdData[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fft_r22sdf_bitrev.sv
// Directed bench for fft_r22sdf_bitrev at N=16: ordering, latency, gaps,
// alignment error, mid-readout reset and a random multi-frame run.
module tb_fft_r22sdf_bitrev;

    localparam int N  = 16;
    localparam int NL = 4;
    localparam int DW = 25;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic [NL-1:0] bin_i;
    logic [DW-1:0] re_i;
    logic [DW-1:0] im_i;
    logic          valid_o;
    logic [NL-1:0] bin_o;
    logic [DW-1:0] re_o;
    logic [DW-1:0] im_o;
    logic          first_o;
    logic          last_o;
    logic          err_o;

    typedef struct {
        logic [NL-1:0] bin;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } expT;

    expT expQ[$];
    int  assertCount = 0;
    int  failCount   = 0;
    int  cyc         = 0;
    int  firstCyc    = -1;
    int  runLen      = 0;
    logic prevValid  = 1'b0;
    int  lastWrCyc   = 0;
    int  frameStart  = 0;
    logic errAfterFirst = 1'b0;

    fft_r22sdf_bitrev #(.N(N), .N_LOG2(NL), .DATA_WIDTH(DW)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .bin_i   (bin_i),
        .re_i    (re_i),
        .im_i    (im_i),
        .valid_o (valid_o),
        .bin_o   (bin_o),
        .re_o    (re_o),
        .im_o    (im_o),
        .first_o (first_o),
        .last_o  (last_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    // Cycle c is the interval following the c-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] bitrev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    // Drive one cycle of input; returns 1 time unit after the sampling edge.
    task automatic applyStimulus(input logic v, input logic [NL-1:0] b,
                                 input logic [DW-1:0] re, input logic [DW-1:0] im);
        valid_i = v;
        bin_i   = b;
        re_i    = re;
        im_i    = im;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, '0, '0, '0);
    endtask

    // Send a frame in bit-reversed order (rotated by rot), optional idle gap
    // of gapLen cycles before sample gapAt, then queue its natural-order image.
    task automatic sendFrame(input int base, input int rot, input bit rnd,
                             input int gapAt, input int gapLen);
        logic [DW-1:0] dRe [N];
        logic [DW-1:0] dIm [N];
        logic [NL-1:0] b;
        expT e;
        for (int k = 0; k < N; k++) begin
            if (rnd) begin
                dRe[k] = DW'($urandom);
                dIm[k] = DW'($urandom);
            end else begin
                dRe[k] = DW'(base + 3 * k);
                dIm[k] = DW'(-(base + k));
            end
        end
        frameStart = cyc;
        for (int i = 0; i < N; i++) begin
            if (i == gapAt) idle(gapLen);
            if (rnd && $urandom_range(0, 7) == 0) idle(1);
            b = bitrev4(4'((i + rot) % N));
            lastWrCyc = cyc;
            applyStimulus(1'b1, b, dRe[b], dIm[b]);
            if (i == 0) errAfterFirst = err_o;
        end
        valid_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            e.bin = NL'(k);
            e.re  = dRe[k];
            e.im  = dIm[k];
            expQ.push_back(e);
        end
    endtask

    // Every valid output must match the head of the expected queue.
    always @(negedge clk) begin
        expT e;
        if (valid_o === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected valid_o", 64'(valid_o), 64'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("bin_o", 64'(bin_o), 64'(e.bin));
                checkOutput("re_o", 64'(re_o), 64'(e.re));
                checkOutput("im_o", 64'(im_o), 64'(e.im));
                checkOutput("first_o", 64'(first_o), 64'(e.bin == 0));
                checkOutput("last_o", 64'(last_o), 64'(e.bin == NL'(N - 1)));
            end
            if (first_o === 1'b1) firstCyc <= cyc;
            runLen <= (prevValid === 1'b1) ? runLen + 1 : 1;
        end
        prevValid <= valid_o;
    end

    initial begin
        bit found;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        bin_i   = '0;
        re_i    = '0;
        im_i    = '0;
        idle(3);
        checkOutput("reset valid_o", 64'(valid_o), 64'd0);
        checkOutput("reset first_o", 64'(first_o), 64'd0);
        checkOutput("reset last_o", 64'(last_o), 64'd0);
        checkOutput("reset err_o", 64'(err_o), 64'd0);
        checkOutput("reset bin_o", 64'(bin_o), 64'd0);
        checkOutput("reset re_o", 64'(re_o), 64'd0);
        checkOutput("reset im_o", 64'(im_o), 64'd0);
        rst_i = 1'b0;
        idle(2);

        $display("[TB] single frame");
        sendFrame(0, 0, 1'b0, -1, 0);
        idle(20);
        checkOutput("single latency", 64'(firstCyc), 64'(lastWrCyc + 2));
        checkOutput("single run length", 64'(runLen), 64'd16);
        checkOutput("single drained", 64'(expQ.size()), 64'd0);
        checkOutput("single err_o", 64'(err_o), 64'd0);

        $display("[TB] three back-to-back frames");
        sendFrame(0, 0, 1'b0, -1, 0);
        sendFrame(100, 0, 1'b0, -1, 0);
        sendFrame(200, 0, 1'b0, -1, 0);
        idle(20);
        checkOutput("b2b run length", 64'(runLen), 64'd48);
        checkOutput("b2b last latency", 64'(firstCyc), 64'(lastWrCyc + 2));
        checkOutput("b2b drained", 64'(expQ.size()), 64'd0);
        checkOutput("b2b err_o", 64'(err_o), 64'd0);

        $display("[TB] frame with 5-cycle gap");
        sendFrame(0, 0, 1'b0, 8, 5);
        idle(20);
        checkOutput("gap latency", 64'(firstCyc), 64'(frameStart + 15 + 5 + 2));
        checkOutput("gap run length", 64'(runLen), 64'd16);
        checkOutput("gap drained", 64'(expQ.size()), 64'd0);

        $display("[TB] misaligned frame");
        checkOutput("err_o before misalign", 64'(err_o), 64'd0);
        sendFrame(500, 2, 1'b0, -1, 0);
        checkOutput("err_o after first sample", 64'(errAfterFirst), 64'd1);
        idle(20);
        checkOutput("err_o held", 64'(err_o), 64'd1);
        checkOutput("misalign drained", 64'(expQ.size()), 64'd0);

        $display("[TB] reset during readout");
        sendFrame(700, 0, 1'b0, -1, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, bitrev4(4'(i)), DW'(900 + i), DW'(950 + i));
        end
        valid_i = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (valid_o === 1'b1 && bin_o === 4'd8) found = 1'b1;
            else idle(1);
        end
        checkOutput("reached bin 8", 64'(found), 64'd1);
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        expQ.delete();
        checkOutput("valid_o after reset", 64'(valid_o), 64'd0);
        checkOutput("err_o after reset", 64'(err_o), 64'd0);
        idle(20);
        sendFrame(1000, 0, 1'b0, -1, 0);
        idle(20);
        checkOutput("post-reset latency", 64'(firstCyc), 64'(lastWrCyc + 2));
        checkOutput("post-reset run length", 64'(runLen), 64'd16);
        checkOutput("post-reset drained", 64'(expQ.size()), 64'd0);
        checkOutput("post-reset err_o", 64'(err_o), 64'd0);

        $display("[TB] random frames");
        for (int f = 0; f < 50; f++) begin
            sendFrame(0, 0, 1'b1, -1, 0);
        end
        idle(20);
        checkOutput("random drained", 64'(expQ.size()), 64'd0);
        checkOutput("random err_o", 64'(err_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
